load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts single core requests and sequences them onto a
// synchronous data memory with a fixed read latency, returning a one-cycle
// completion pulse.
//
// Optional feature macro: LSU_WRITE_VERIFY_EN
//   When defined, every store is read back from the same address and
//   resp_error flags a readback mismatch. When undefined, resp_error is 0.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   core request handshake
//   req_write             1 = store, 0 = load
//   req_addr, req_wdata   request address and store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata            load (or readback) data, held until next capture
//   resp_error            store readback mismatch, qualified by resp_valid
//   busy                  transaction in flight
//   mem_*                 data memory address/data/enables and read data
module load_store_unit #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
`ifdef LSU_WRITE_VERIFY_EN
    ,
    VREAD = 3'd5,
    VWAIT = 3'd6
`endif
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic              accept_c;
  logic              waiting_c;
  logic              wait_last_c;
  logic              capture_c;

  // Next-state and datapath strobes.
  always_comb begin
    state_next  = state;
    accept_c    = 1'b0;
    waiting_c   = 1'b0;
    wait_last_c = 1'b0;
    capture_c   = 1'b0;

`ifdef LSU_WRITE_VERIFY_EN
    waiting_c = (state == WAIT) || (state == VWAIT);
`else
    waiting_c = (state == WAIT);
`endif
    wait_last_c = (wait_cnt == CNT_W'(READ_LAT - 1));
    capture_c   = waiting_c && wait_last_c;

    case (state)
      IDLE: begin
        accept_c = req_valid;
        if (req_valid) begin
          state_next = req_write ? WRITE : READ;
        end
      end
`ifdef LSU_WRITE_VERIFY_EN
      WRITE: state_next = VREAD;
      VREAD: state_next = VWAIT;
      VWAIT: if (wait_last_c) state_next = RESP;
`else
      WRITE: state_next = RESP;
`endif
      READ:  state_next = WAIT;
      WAIT:  if (wait_last_c) state_next = RESP;
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs, all decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      req_ready        <= 1'b1;
      busy             <= 1'b0;
      resp_valid       <= 1'b0;
      resp_rdata       <= '0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
    end else begin
      state            <= state_next;
      req_ready        <= (state_next == IDLE);
      busy             <= (state_next != IDLE);
      resp_valid       <= (state_next == RESP);
      mem_write_enable <= (state_next == WRITE);
`ifdef LSU_WRITE_VERIFY_EN
      mem_read_enable  <= (state_next == READ) || (state_next == VREAD);
`else
      mem_read_enable  <= (state_next == READ);
`endif
      wait_cnt <= (waiting_c && !wait_last_c) ? wait_cnt + CNT_W'(1) : '0;
      if (accept_c) begin
        mem_address    <= req_addr;
        mem_write_data <= req_wdata;
      end
      if (capture_c) begin
        resp_rdata <= mem_read_data;
      end
    end
  end

`ifdef LSU_WRITE_VERIFY_EN
  logic resp_error_q;

  // Mismatch flag is only set on the cycle entering RESP from VWAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_error_q <= 1'b0;
    end else begin
      resp_error_q <= capture_c && (state == VWAIT) &&
                      (mem_read_data != mem_write_data);
    end
  end

  assign resp_error = resp_error_q;
`else
  assign resp_error = 1'b0;
`endif

endmodule
